// File: rtl/riscv_pkg.sv
// Shared definitions for the RV32I core pipeline.
// Holds fetch constants and the fetch FSM state type.
package riscv_pkg;

   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
   localparam logic [31:0] RESET_PC  = 32'h0000_0000;

   typedef enum logic {
      RUN   = 1'b0,
      DRAIN = 1'b1
   } fetch_state_e;

endpackage

// File: rtl/fetch_buf.sv
// Fetch ring buffer: entries allocated on request, filled on response,
// freed on pop; reports occupancy and outstanding (allocated, unfilled).
module fetch_buf #(
   parameter  int DEPTH = 4,
   localparam int AW    = $clog2(DEPTH),
   localparam int PW    = AW + 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          flush,
   input  logic          alloc_en,
   input  logic [31:0]   alloc_pc,
   input  logic          fill_en,
   input  logic [31:0]   fill_data,
   input  logic          pop_en,
   output logic          head_valid,
   output logic [31:0]   head_pc,
   output logic [31:0]   head_instr,
   output logic [PW-1:0] occupancy,
   output logic [PW-1:0] outstanding
);

   logic [PW-1:0]    alloc_q, alloc_d;
   logic [PW-1:0]    fill_q, fill_d;
   logic [PW-1:0]    head_q, head_d;
   logic [DEPTH-1:0] filled_q, filled_d;
   logic [31:0]      pc_q [DEPTH];
   logic [31:0]      pc_d [DEPTH];
   logic [31:0]      instr_q [DEPTH];
   logic [31:0]      instr_d [DEPTH];

   assign occupancy   = alloc_q - head_q;
   assign outstanding = alloc_q - fill_q;
   assign head_valid  = filled_q[head_q[AW-1:0]];
   assign head_pc     = pc_q[head_q[AW-1:0]];
   assign head_instr  = instr_q[head_q[AW-1:0]];

   // Pointer, fill-flag and payload updates; flush empties the ring
   always_comb begin
      alloc_d  = alloc_q;
      fill_d   = fill_q;
      head_d   = head_q;
      filled_d = filled_q;
      pc_d     = pc_q;
      instr_d  = instr_q;
      if (flush) begin
         alloc_d  = '0;
         fill_d   = '0;
         head_d   = '0;
         filled_d = '0;
      end else begin
         if (alloc_en) begin
            pc_d[alloc_q[AW-1:0]] = alloc_pc;
            alloc_d = alloc_q + PW'(1);
         end
         if (fill_en) begin
            instr_d[fill_q[AW-1:0]]  = fill_data;
            filled_d[fill_q[AW-1:0]] = 1'b1;
            fill_d = fill_q + PW'(1);
         end
         if (pop_en) begin
            filled_d[head_q[AW-1:0]] = 1'b0;
            head_d = head_q + PW'(1);
         end
      end
   end

   // Control state with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         alloc_q  <= '0;
         fill_q   <= '0;
         head_q   <= '0;
         filled_q <= '0;
      end else begin
         alloc_q  <= alloc_d;
         fill_q   <= fill_d;
         head_q   <= head_d;
         filled_q <= filled_d;
      end
   end

   // Payload storage needs no reset; fill flags guard it
   always_ff @(posedge clk) begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
   end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch front end: PC, request channel, redirect drain FSM.
// Optional FETCH_PERF_EN adds pop and redirect counters.
module fetch_stage #(
   parameter logic [31:0] RESET_PC = riscv_pkg::RESET_PC,
   parameter int          DEPTH    = 4
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_req_addr,
   input  logic        imem_rsp_valid,
   input  logic [31:0] imem_rsp_data,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic [31:0] InstrD,
   output logic [31:0] PCD,
   output logic [31:0] PCPlus4D,
   output logic        ValidD,
   input  logic        StallD
`ifdef FETCH_PERF_EN
   ,
   output logic [31:0] perf_fetch_cnt,
   output logic [31:0] perf_redirect_cnt
`endif
);

   import riscv_pkg::*;

   localparam int PW = $clog2(DEPTH) + 1;

   fetch_state_e  state_q, state_d;
   logic [31:0]   pc_q, pc_d;
   logic [PW-1:0] drop_q, drop_d;

   logic          req_fire, rsp_take, rsp_hit, pop, flush;
   logic          head_valid;
   logic [31:0]   head_pc, head_instr, redir_pc;
   logic [PW-1:0] occupancy, outstanding;

   assign redir_pc = redirect_pc & ~32'h3;
   assign rsp_hit  = imem_rsp_valid && (outstanding != '0);

   assign imem_req_valid = !rst && (state_q == RUN) &&
                           (occupancy < PW'(DEPTH)) && !redirect_valid;
   assign imem_req_addr  = pc_q;
   assign req_fire = imem_req_valid && imem_req_ready;
   assign flush    = !rst && redirect_valid;
   assign rsp_take = !rst && !redirect_valid && (state_q == RUN) && rsp_hit;
   assign pop      = !rst && !redirect_valid && head_valid && !StallD;

   assign ValidD   = head_valid;
   assign InstrD   = head_valid ? head_instr : NOP_INSTR;
   assign PCD      = head_valid ? head_pc : 32'h0;
   assign PCPlus4D = head_valid ? head_pc + 32'd4 : 32'h0;

   fetch_buf #(.DEPTH(DEPTH)) u_buf (
      .clk         (clk),
      .rst         (rst),
      .flush       (flush),
      .alloc_en    (req_fire),
      .alloc_pc    (pc_q),
      .fill_en     (rsp_take),
      .fill_data   (imem_rsp_data),
      .pop_en      (pop),
      .head_valid  (head_valid),
      .head_pc     (head_pc),
      .head_instr  (head_instr),
      .occupancy   (occupancy),
      .outstanding (outstanding)
   );

   // Next PC, drain count and state; a response during redirect is dropped
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      drop_d  = drop_q;
      unique case (state_q)
         RUN: begin
            if (redirect_valid) begin
               pc_d   = redir_pc;
               drop_d = outstanding - PW'(rsp_hit);
               if (drop_d != '0) state_d = DRAIN;
            end else if (req_fire) begin
               pc_d = pc_q + 32'd4;
            end
         end
         DRAIN: begin
            if (redirect_valid) pc_d = redir_pc;
            if (imem_rsp_valid && (drop_q != '0)) begin
               drop_d = drop_q - PW'(1);
               if (drop_d == '0) state_d = RUN;
            end
         end
      endcase
   end

   // PC, FSM and drain counter registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= RUN;
         pc_q    <= RESET_PC;
         drop_q  <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         drop_q  <= drop_d;
      end
   end

   // A response with nothing outstanding is a memory protocol error
   assert property (@(posedge clk) disable iff (rst)
      (state_q == RUN && imem_rsp_valid) |-> (outstanding != '0));

`ifdef FETCH_PERF_EN
   logic [31:0] perf_fetch_q, perf_fetch_d;
   logic [31:0] perf_redir_q, perf_redir_d;

   assign perf_fetch_cnt    = perf_fetch_q;
   assign perf_redirect_cnt = perf_redir_q;

   // Wrapping counts of pops and redirect cycles
   always_comb begin
      perf_fetch_d = perf_fetch_q + 32'(pop);
      perf_redir_d = perf_redir_q + 32'(flush);
   end

   // Counter registers
   always_ff @(posedge clk) begin
      if (rst) begin
         perf_fetch_q <= '0;
         perf_redir_q <= '0;
      end else begin
         perf_fetch_q <= perf_fetch_d;
         perf_redir_q <= perf_redir_d;
      end
   end
`else
   // Counters are absent in this build
`endif

endmodule
